sram_scan_ctrl: RTL and testbench

Parametrised dual-port RAM with a self-timed read scanner, generalising the board-level SRAM demo block. The RAM has a free-running write port driven from switches or upstream logic. A read address sweeps the memory automatically (up or down), steps manually on a button, or holds. The block exports registered read data, the current read address and a valid strobe for the seven-segment display layer. A write-first bypass gives defined read-during-write behaviour.

---
 rtl/sram_scan_ctrl.sv | 118 +++++++++++
 tb/tb_sram_scan_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_scan_ctrl.sv
// sram_scan_ctrl: dual-port RAM with a self-timed read-address scanner.
// A free-running write port fills the array; the read address sweeps up/down
// on a divider tick, steps on a synchronised button edge, or holds. Read data
// is registered with a write-first bypass, and a valid strobe marks the first
// cycle that rd_data reflects a new rd_addr.
module sram_scan_ctrl #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 5,
   parameter int DIV_W  = 25
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [1:0]        mode,
   input  logic              step,
   input  logic              clr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              tick
);

   typedef enum logic [1:0] {
      MODE_UP     = 2'b00,
      MODE_DOWN   = 2'b01,
      MODE_MANUAL = 2'b10,
      MODE_HOLD   = 2'b11
   } scan_mode_e;

   scan_mode_e        scan_mode;
   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DIV_W-1:0]  div;
   logic              step_s1;
   logic              step_s2;
   logic              step_d;
   logic              step_pulse;
   logic [ADDR_W-1:0] addr_nxt;
   logic              addr_chg;

   assign scan_mode = scan_mode_e'(mode);
   assign tick      = &div;

   // Free-running scan divider; clr realigns it so the next tick is a full period away.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         div <= '0;
      end else if (clr) begin
         div <= '0;
      end else begin
         div <= div + DIV_W'(1);
      end
   end

   // Two-flop synchroniser, edge-detect history and registered step pulse.
   // The pulse is registered so a press sampled at edge N advances at N+3.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         step_s1    <= 1'b0;
         step_s2    <= 1'b0;
         step_d     <= 1'b0;
         step_pulse <= 1'b0;
      end else begin
         step_s1    <= step;
         step_s2    <= step_s1;
         step_d     <= step_s2;
         step_pulse <= step_s2 & ~step_d;
      end
   end

   // Next read address: clr wins, otherwise advance according to the scan mode.
   always_comb begin
      addr_nxt = rd_addr;
      if (clr) begin
         addr_nxt = '0;
      end else begin
         case (scan_mode)
            MODE_UP:     if (tick)       addr_nxt = rd_addr + ADDR_W'(1);
            MODE_DOWN:   if (tick)       addr_nxt = rd_addr - ADDR_W'(1);
            MODE_MANUAL: if (step_pulse) addr_nxt = rd_addr + ADDR_W'(1);
            default:                     addr_nxt = rd_addr;
         endcase
      end
   end

   // Read address register; a change is flagged so rd_valid lines up with rd_data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr  <= '0;
         addr_chg <= 1'b0;
         rd_valid <= 1'b0;
      end else begin
         rd_addr  <= addr_nxt;
         addr_chg <= (addr_nxt != rd_addr);
         rd_valid <= addr_chg;
      end
   end

   // RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read with write-first bypass on an address collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (we && (wr_addr == rd_addr)) begin
         rd_data <= wr_data;
      end else begin
         rd_data <= mem[rd_addr];
      end
   end

endmodule

// File: tb/tb_sram_scan_ctrl.sv
// Directed bench for sram_scan_ctrl with a short divider (8-cycle tick period).
module tb_sram_scan_ctrl;

   localparam int DATA_W = 4;
   localparam int ADDR_W = 5;
   localparam int DIV_W  = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              we;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic [1:0]        mode;
   logic              step;
   logic              clr;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              tick;

   int vec_cnt  = 0;
   int err_cnt  = 0;

   sram_scan_ctrl #(
      .DATA_W(DATA_W),
      .ADDR_W(ADDR_W),
      .DIV_W (DIV_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .we      (we),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .mode    (mode),
      .step    (step),
      .clr     (clr),
      .rd_addr (rd_addr),
      .rd_data (rd_data),
      .rd_valid(rd_valid),
      .tick    (tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n clock edges and settle 1 ns past the last one.
   task automatic cyc(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Bounded wait for rd_addr to reach a target; a timeout shows up as a miscompare.
   task automatic wait_addr(input string tag, input int target, input int budget);
      int n;
      n = 0;
      while ((int'(rd_addr) != target) && (n < budget)) begin
         cyc(1);
         n++;
      end
      chk(tag, 32'(rd_addr), 32'(target));
   endtask

   initial begin
      int n;
      rst = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0;
      mode = 2'b11; step = 1'b0; clr = 1'b0;
      #12;
      chk("rst_rd_addr",  32'(rd_addr),  32'd0);
      chk("rst_rd_data",  32'(rd_data),  32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_tick",     32'(tick),     32'd0);

      // First tick lands 8 cycles after release.
      @(negedge clk);
      rst = 1'b0;
      cyc(6);
      chk("first_tick_lo", 32'(tick), 32'd0);
      cyc(1);
      chk("first_tick_hi", 32'(tick), 32'd1);

      // Fill mem[i] = i[3:0] while holding.
      for (int i = 0; i < 32; i++) begin
         we = 1'b1; wr_addr = i[4:0]; wr_data = i[3:0];
         cyc(1);
      end
      we = 1'b0;
      chk("hold_addr", 32'(rd_addr), 32'd0);

      // clr at address 0 aligns the divider and gives no strobe.
      clr = 1'b1; mode = 2'b00;
      cyc(1);
      clr = 1'b0;
      cyc(1);
      chk("clr0_no_valid", 32'(rd_valid), 32'd0);
      chk("clr0_rd_data",  32'(rd_data),  32'd0);
      cyc(6);

      // Scan up: one step per 8 cycles, data and strobe one cycle later.
      for (int k = 1; k <= 4; k++) begin
         chk("up_tick",      32'(tick),     32'd1);
         chk("up_pre_addr",  32'(rd_addr),  32'(k - 1));
         cyc(1);
         chk("up_addr",      32'(rd_addr),  32'(k));
         chk("up_valid_lag", 32'(rd_valid), 32'd0);
         cyc(1);
         chk("up_data",      32'(rd_data),  32'(k));
         chk("up_valid",     32'(rd_valid), 32'd1);
         cyc(1);
         chk("up_valid_end", 32'(rd_valid), 32'd0);
         cyc(5);
      end

      // Wrap upward 31 -> 0.
      wait_addr("reach_31", 31, 300);
      cyc(7);
      chk("wrap_up_pre", 32'(rd_addr), 32'd31);
      cyc(1);
      chk("wrap_up",     32'(rd_addr), 32'd0);

      // Wrap downward 0 -> 31 -> 30.
      mode = 2'b01;
      cyc(8);
      chk("wrap_dn",       32'(rd_addr),  32'd31);
      cyc(1);
      chk("wrap_dn_data",  32'(rd_data),  32'd15);
      chk("wrap_dn_valid", 32'(rd_valid), 32'd1);
      cyc(7);
      chk("dn_30",         32'(rd_addr),  32'd30);

      // Collision at address 5 in hold.
      wait_addr("reach_5", 5, 300);
      mode = 2'b11;
      cyc(2);
      chk("hold5_data", 32'(rd_data), 32'd5);
      we = 1'b1; wr_addr = 5'd5; wr_data = 4'hA;
      cyc(1);
      chk("bypass_A", 32'(rd_data), 32'hA);
      wr_addr = 5'd6; wr_data = 4'd3;
      cyc(1);
      chk("other_wr_keep", 32'(rd_data), 32'hA);
      we = 1'b0;
      cyc(10);
      chk("hold_no_adv", 32'(rd_addr), 32'd5);
      chk("hold_mem5",   32'(rd_data), 32'hA);

      // Manual step held high: one increment at N+3, ticks ignored.
      mode = 2'b10; step = 1'b1;
      cyc(3);
      chk("man_n2", 32'(rd_addr), 32'd5);
      cyc(1);
      chk("man_n3", 32'(rd_addr), 32'd6);
      cyc(1);
      chk("man_data6", 32'(rd_data), 32'd3);
      cyc(15);
      chk("man_held", 32'(rd_addr), 32'd6);
      step = 1'b0;
      cyc(4);
      chk("man_release", 32'(rd_addr), 32'd6);

      // Three short presses take the address to 9.
      for (int p = 0; p < 3; p++) begin
         step = 1'b1;
         cyc(1);
         step = 1'b0;
         cyc(4);
      end
      chk("man_9", 32'(rd_addr), 32'd9);

      // clr against a tick at address 9.
      mode = 2'b11;
      n = 0;
      while (!tick && n < 20) begin
         cyc(1);
         n++;
      end
      chk("find_tick", 32'(tick), 32'd1);
      clr = 1'b1; mode = 2'b00;
      cyc(1);
      clr = 1'b0;
      chk("clr_addr", 32'(rd_addr), 32'd0);
      cyc(1);
      chk("clr_valid", 32'(rd_valid), 32'd1);
      chk("clr_data",  32'(rd_data),  32'd0);
      cyc(5);
      chk("clr_tick_lo", 32'(tick), 32'd0);
      cyc(1);
      chk("clr_tick_hi", 32'(tick), 32'd1);
      cyc(1);
      chk("clr_next", 32'(rd_addr), 32'd1);

      // Reset mid-scan at address 17.
      wait_addr("reach_17", 17, 300);
      cyc(1);
      chk("pre_rst_valid", 32'(rd_valid), 32'd1);
      chk("pre_rst_data",  32'(rd_data),  32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_addr",  32'(rd_addr),  32'd0);
      chk("mid_rst_data",  32'(rd_data),  32'd0);
      chk("mid_rst_valid", 32'(rd_valid), 32'd0);
      chk("mid_rst_tick",  32'(tick),     32'd0);
      mode = 2'b10;
      @(negedge clk);
      rst = 1'b0;
      step = 1'b1;
      cyc(4);
      step = 1'b0;
      chk("post_rst_addr", 32'(rd_addr), 32'd1);
      cyc(1);
      chk("post_rst_data",  32'(rd_data),  32'd1);
      chk("post_rst_valid", 32'(rd_valid), 32'd1);
      for (int p = 0; p < 5; p++) begin
         step = 1'b1;
         cyc(1);
         step = 1'b0;
         cyc(4);
      end
      chk("post_rst_addr6", 32'(rd_addr), 32'd6);
      cyc(1);
      chk("post_rst_mem6",  32'(rd_data), 32'd3);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
